// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 8-bit ALU among NUM_REQ requesters.
// One operation in flight; result returned tagged with requester id over valid/ready.
module alu_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ALU_WAIT = 1,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic [NUM_REQ-1:0]          req_valid_in,
    output logic [NUM_REQ-1:0]          req_ready_out,
    input  logic [NUM_REQ-1:0][7:0]     req_d0_in,
    input  logic [NUM_REQ-1:0][7:0]     req_d1_in,
    input  logic [NUM_REQ-1:0][2:0]     req_sel_in,
    output logic [7:0]                  alu_d0_out,
    output logic [7:0]                  alu_d1_out,
    output logic [2:0]                  alu_sel_out,
    input  logic [15:0]                 alu_res_in,
    input  logic                        alu_gt_in,
    input  logic                        alu_eq_in,
    output logic                        resp_valid_out,
    input  logic                        resp_ready_in,
    output logic [ID_W-1:0]             resp_id_out,
    output logic [15:0]                 resp_res_out,
    output logic                        resp_gt_out,
    output logic                        resp_eq_out,
    output logic                        busy_out
);

    localparam int unsigned CNT_W = $clog2(ALU_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [CNT_W-1:0]  cnt;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   scan_idx;
    logic              grant_found;

    // First valid requester at or after the round-robin pointer
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            scan_idx = ID_W'((32'(ptr) + i) % NUM_REQ);
            if (!grant_found && req_valid_in[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Grant is only offered while idle and out of reset
    assign req_ready_out = (rst_n_in && (state == IDLE) && grant_found)
                         ? (NUM_REQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state          <= IDLE;
            ptr            <= '0;
            cnt            <= '0;
            alu_d0_out     <= '0;
            alu_d1_out     <= '0;
            alu_sel_out    <= '0;
            resp_valid_out <= 1'b0;
            resp_id_out    <= '0;
            resp_res_out   <= '0;
            resp_gt_out    <= 1'b0;
            resp_eq_out    <= 1'b0;
            busy_out       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        alu_d0_out  <= req_d0_in[grant_idx];
                        alu_d1_out  <= req_d1_in[grant_idx];
                        alu_sel_out <= req_sel_in[grant_idx];
                        resp_id_out <= grant_idx;
                        cnt         <= CNT_W'(ALU_WAIT);
                        busy_out    <= 1'b1;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == CNT_W'(1)) begin
                        resp_res_out   <= alu_res_in;
                        resp_gt_out    <= alu_gt_in;
                        resp_eq_out    <= alu_eq_in;
                        resp_valid_out <= 1'b1;
                        state          <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    // Next search starts just past the requester just served
                    if (resp_ready_in) begin
                        resp_valid_out <= 1'b0;
                        busy_out       <= 1'b0;
                        ptr            <= ID_W'((32'(resp_id_out) + 1) % NUM_REQ);
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: scoreboard on responses plus directed timing checks.
module tb_alu_arbiter;

    logic clk_in = 1'b0;
    logic rst_n_in;
    always #5 clk_in = ~clk_in;

    // Main instance, ALU_WAIT = 1
    logic [3:0]      req_valid, req_ready;
    logic [3:0][7:0] req_d0, req_d1;
    logic [3:0][2:0] req_sel;
    logic [7:0]      alu_d0, alu_d1;
    logic [2:0]      alu_sel;
    logic [15:0]     alu_res, resp_res;
    logic            alu_gt, alu_eq, resp_valid, resp_ready, resp_gt, resp_eq, busy;
    logic [1:0]      resp_id;

    assign alu_res = {alu_d1, alu_d0};
    assign alu_gt  = alu_d0 > alu_d1;
    assign alu_eq  = alu_d0 == alu_d1;

    alu_arbiter #(.NUM_REQ(4), .ALU_WAIT(1)) u_dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req_valid_in(req_valid), .req_ready_out(req_ready),
        .req_d0_in(req_d0), .req_d1_in(req_d1), .req_sel_in(req_sel),
        .alu_d0_out(alu_d0), .alu_d1_out(alu_d1), .alu_sel_out(alu_sel),
        .alu_res_in(alu_res), .alu_gt_in(alu_gt), .alu_eq_in(alu_eq),
        .resp_valid_out(resp_valid), .resp_ready_in(resp_ready),
        .resp_id_out(resp_id), .resp_res_out(resp_res),
        .resp_gt_out(resp_gt), .resp_eq_out(resp_eq), .busy_out(busy)
    );

    // Second instance, ALU_WAIT = 3
    logic [3:0]      w3_valid, w3_ready;
    logic [3:0][7:0] w3_d0, w3_d1;
    logic [3:0][2:0] w3_sel;
    logic [7:0]      w3_alu_d0, w3_alu_d1;
    logic [2:0]      w3_alu_sel;
    logic [15:0]     w3_alu_res, w3_res;
    logic            w3_alu_gt, w3_alu_eq, w3_rvalid, w3_rready, w3_gt, w3_eq, w3_busy;
    logic [1:0]      w3_id;

    assign w3_alu_res = {w3_alu_d1, w3_alu_d0};
    assign w3_alu_gt  = w3_alu_d0 > w3_alu_d1;
    assign w3_alu_eq  = w3_alu_d0 == w3_alu_d1;

    alu_arbiter #(.NUM_REQ(4), .ALU_WAIT(3)) u_w3 (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .req_valid_in(w3_valid), .req_ready_out(w3_ready),
        .req_d0_in(w3_d0), .req_d1_in(w3_d1), .req_sel_in(w3_sel),
        .alu_d0_out(w3_alu_d0), .alu_d1_out(w3_alu_d1), .alu_sel_out(w3_alu_sel),
        .alu_res_in(w3_alu_res), .alu_gt_in(w3_alu_gt), .alu_eq_in(w3_alu_eq),
        .resp_valid_out(w3_rvalid), .resp_ready_in(w3_rready),
        .resp_id_out(w3_id), .resp_res_out(w3_res),
        .resp_gt_out(w3_gt), .resp_eq_out(w3_eq), .busy_out(w3_busy)
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] res;
        logic        gt;
        logic        eq;
    } exp_t;

    exp_t sb[$];
    exp_t got_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_resp  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] id, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.id  = id;
        e.res = {b, a};
        e.gt  = a > b;
        e.eq  = a == b;
        return e;
    endfunction

    // Response monitor: values seen here are what the next rising edge transfers
    always @(negedge clk_in) begin
        if (rst_n_in && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                got_e = sb.pop_front();
                check("resp_id",  32'(resp_id),  32'(got_e.id));
                check("resp_res", 32'(resp_res), 32'(got_e.res));
                check("resp_gt",  32'(resp_gt),  32'(got_e.gt));
                check("resp_eq",  32'(resp_eq),  32'(got_e.eq));
                n_resp++;
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        w3_valid  = '0;
        rst_n_in  = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        @(posedge clk_in);
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk_in);
            k++;
        end
        #1;
        check("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, k;
        rst_n_in   = 1'b0;
        req_valid  = 4'b1111;
        w3_valid   = 4'b1111;
        resp_ready = 1'b1;
        w3_rready  = 1'b1;
        for (int r = 0; r < 4; r++) begin
            req_d0[r] = 8'(16 * r + 3);
            req_d1[r] = 8'(40 - 10 * r);
            req_sel[r] = 3'(r);
            w3_d0[r] = 8'(r + 1);
            w3_d1[r] = 8'(r + 2);
            w3_sel[r] = 3'(r);
        end

        // Reset held with requests pending
        repeat (3) @(negedge clk_in);
        check("rst_ready",     32'(req_ready),  32'd0);
        check("rst_busy",      32'(busy),       32'd0);
        check("rst_rvalid",    32'(resp_valid), 32'd0);
        check("rst_res",       32'(resp_res),   32'd0);
        check("rst_id",        32'(resp_id),    32'd0);
        check("rst_gteq",      32'({resp_gt, resp_eq}), 32'd0);
        check("rst_alu",       32'({alu_d0, alu_d1, alu_sel}), 32'd0);
        check("rst_w3_ready",  32'(w3_ready),   32'd0);
        check("rst_w3_busy",   32'(w3_busy),    32'd0);
        do_reset();

        // Single op on requester 0
        req_d0[0] = 8'd100; req_d1[0] = 8'd10; req_sel[0] = 3'd3;
        req_valid = 4'b0001;
        sb.push_back(mk(2'd0, 8'd100, 8'd10));
        @(negedge clk_in);
        check("single_ready", 32'(req_ready), 32'b0001);
        check("single_idle_busy", 32'(busy), 32'd0);
        step();
        req_valid = '0;
        @(negedge clk_in);
        check("single_alu_d0",  32'(alu_d0),  32'd100);
        check("single_alu_d1",  32'(alu_d1),  32'd10);
        check("single_alu_sel", 32'(alu_sel), 32'd3);
        check("single_busy",    32'(busy),    32'd1);
        check("single_rvalid0", 32'(resp_valid), 32'd0);
        check("single_ready_exec", 32'(req_ready), 32'd0);
        @(negedge clk_in);
        check("single_rvalid1", 32'(resp_valid), 32'd1);
        check("single_res",     32'(resp_res),   32'h0A64);
        wait_drain();

        // Fairness from a fresh pointer: 0,1,2,3,0 then only req2
        do_reset();
        for (int r = 0; r < 4; r++) begin
            req_d0[r] = 8'(16 * r + 3);
            req_d1[r] = 8'(40 - 10 * r);
        end
        for (int n = 0; n < 5; n++)
            sb.push_back(mk(2'(n % 4), 8'(16 * (n % 4) + 3), 8'(40 - 10 * (n % 4))));
        sb.push_back(mk(2'd2, 8'd35, 8'd20));
        base = n_resp;
        req_valid = 4'b1111;
        k = 0;
        while ((n_resp - base) < 5 && k < 100) begin
            step();
            k++;
        end
        check("fair_count", 32'(n_resp - base), 32'd5);
        req_valid = 4'b0100;
        @(negedge clk_in);
        check("fair_req2_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        wait_drain();

        // Backpressure: pointer now 3, requester 1 also waiting
        resp_ready = 1'b0;
        req_d0[3] = 8'd7;   req_d1[3] = 8'd7;  req_sel[3] = 3'd1;
        req_d0[1] = 8'd200; req_d1[1] = 8'd5;
        sb.push_back(mk(2'd3, 8'd7, 8'd7));
        sb.push_back(mk(2'd1, 8'd200, 8'd5));
        req_valid = 4'b1010;
        @(negedge clk_in);
        check("bp_ready", 32'(req_ready), 32'b1000);
        step();
        req_valid = 4'b0010;
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_in);
            check("bp_rvalid", 32'(resp_valid), 32'd1);
            check("bp_res",    32'(resp_res),   32'h0707);
            check("bp_flags",  32'({resp_gt, resp_eq}), 32'b01);
            check("bp_id",     32'(resp_id),    32'd3);
            check("bp_ready_hold", 32'(req_ready), 32'd0);
        end
        step();
        resp_ready = 1'b1;
        @(negedge clk_in);
        check("bp_rvalid_last", 32'(resp_valid), 32'd1);
        step();
        @(negedge clk_in);
        check("bp_released", 32'(resp_valid), 32'd0);
        step();
        req_valid = '0;
        wait_drain();

        // ALU_WAIT = 3 timing on the second instance
        w3_d0[2] = 8'd55; w3_d1[2] = 8'd66; w3_sel[2] = 3'd5;
        w3_valid = 4'b0100;
        step();
        w3_valid = '0;
        for (int e = 0; e < 3; e++) begin
            @(negedge clk_in);
            check("w3_alu_d0",  32'(w3_alu_d0),  32'd55);
            check("w3_alu_d1",  32'(w3_alu_d1),  32'd66);
            check("w3_alu_sel", 32'(w3_alu_sel), 32'd5);
            check("w3_rvalid_low", 32'(w3_rvalid), 32'd0);
            check("w3_busy",    32'(w3_busy),    32'd1);
            step();
        end
        @(negedge clk_in);
        check("w3_rvalid_high", 32'(w3_rvalid), 32'd1);
        check("w3_res",  32'(w3_res), 32'h4237);
        check("w3_id",   32'(w3_id),  32'd2);
        check("w3_flags", 32'({w3_gt, w3_eq}), 32'b00);
        step();
        @(negedge clk_in);
        check("w3_done", 32'({w3_rvalid, w3_busy}), 32'b00);

        // Reset mid-EXEC abandons the op; pointer restarts at 0
        step();
        req_d0[1] = 8'd9; req_d1[1] = 8'd1;
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        rst_n_in  = 1'b0;
        @(negedge clk_in);
        check("midrst_busy",   32'(busy),       32'd0);
        check("midrst_rvalid", 32'(resp_valid), 32'd0);
        check("midrst_alu",    32'(alu_d0),     32'd0);
        step();
        rst_n_in = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_in);
            check("midrst_no_resp", 32'(resp_valid), 32'd0);
        end
        step();
        req_d0[0] = 8'd1; req_d1[0] = 8'd2;
        req_d0[3] = 8'd3; req_d1[3] = 8'd4;
        sb.push_back(mk(2'd0, 8'd1, 8'd2));
        req_valid = 4'b1001;
        @(negedge clk_in);
        check("midrst_ptr", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
